fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the decode stage. Owns the PC and issues in-order reads to
//  instruction memory, with up to DEPTH requests outstanding. Buffers returned words in a small
//  prefetch queue and hands {instr, pc_inc} to decode over a valid/ready handshake.
//  Handles EX-stage redirects (taken branch/jump) and decode-stage halt.
// PARAMETERS
//  DEPTH     2        max (queued words + in-flight requests); queue capacity; >=1
//  RESET_PC  16'h0000 PC loaded on reset; bit0 must be 0
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-low (0 = reset, sampled on clk rising edge)
//  imem_req     out  1   read request; always accepted by memory in the cycle it is asserted
//  imem_addr    out  16  request address (current fetch PC)
//  imem_valid   in   1   read response valid; responses in request order, >=1 cycle after req
//  imem_data    in   16  response instruction word
//  redirect     in   1   EX redirect: flush and refetch from redirect_pc
//  redirect_pc  in   16  redirect target; bit0 forced to 0 internally
//  halt         in   1   decode saw HALT: stop fetching until reset
//  if_valid     out  1   queue head valid toward decode
//  if_ready     in   1   decode accepts head when if_valid&&if_ready
//  if_instr     out  16  head instruction word
//  if_pc_inc    out  16  head fetch address + 2 (mod 2^16)
//  halted       out  1   1 while in HALTED state
// BEHAVIOUR
//  - Reset (rst=0): pc=RESET_PC; queue empty; inflight=0; drop=0; state=RUN.
//    Outputs while in reset: imem_req=0, if_valid=0, if_instr=0, if_pc_inc=0, halted=0.
//  - FSM: RUN -> HALTED on halt=1 && redirect=0. HALTED exits only by reset. No other states.
//  - Issue (RUN only): imem_req=1 when occupancy+inflight < DEPTH and no redirect/halt this cycle.
//    On issue: imem_addr=pc, pc<=pc+2 (16'hFFFE wraps to 16'h0000), inflight++.
//    Each queue entry stores the word and its addr+2.
//  - Response: imem_valid with drop>0 -> discard, drop--.
//    imem_valid with inflight==0 -> ignore (stale, e.g. across reset).
//    Otherwise push into queue; inflight--.
//    Space is guaranteed by the issue rule; an overflow is a design bug (assert in TB).
//  - Pop: if_valid&&if_ready removes the head. Push and pop in the same cycle are both performed.
//    Head outputs hold stable while if_valid=1 && if_ready=0.
//  - Redirect (any state other than HALTED): handshake in that cycle still completes.
//    Then: queue flushed; drop <= drop + inflight (including any response arriving this cycle,
//    which is discarded); inflight <= 0; pc <= {redirect_pc[15:1],1'b0}; imem_req=0 this cycle.
//    First new request is issued the next cycle.
//  - Simultaneous redirect and halt: redirect wins and halt is ignored.
//  - Halt (RUN): imem_req=0 from that cycle; queue flushed; in-flight responses discarded via drop.
//    if_valid=0 from the next cycle; halted=1 from the next cycle.
//  - Reset mid-operation aborts everything. Responses arriving after reset with inflight==0 are
//    ignored.
//  - Latency, no bypass: imem_valid in cycle N -> if_valid in cycle N+1 (empty queue).
//    With 1-cycle memory and if_ready=1, sustained throughput is 1 instr/cycle once DEPTH>=2.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when the queue is empty and drop==0, an accepted response is driven
//  combinationally onto if_instr/if_pc_inc with if_valid=1 in the same cycle.
//  If if_ready=1 the word is consumed and not enqueued; otherwise it is enqueued as normal.
//  Latency becomes 0 cycles.
//  FETCH_BYPASS_EN undefined: if_* are driven only from queue registers; 1-cycle latency as above.
// TESTING
//  1. rst=0 for 3 cycles, then 1 -> imem_req=0 and if_valid=0 during reset;
//     imem_req=1 with imem_addr=16'h0000 in the first cycle after release.
//  2. 1-cycle memory returning addr^16'hA5A5, if_ready=1 for 10 instrs -> if_pc_inc=2,4,..,20
//     in order, no gaps after the first.
//  3. if_ready=0 for 6 cycles mid-stream -> at most 2 requests outstanding/queued, if_* stable;
//     on release, order preserved with no loss or duplication.
//  4. redirect=1, redirect_pc=16'h0041, with 2 requests in flight -> next imem_addr=16'h0040;
//     both stale responses never appear; first if_pc_inc=16'h0042.
//  5. halt=1 (redirect=0) -> imem_req=0 that cycle; halted=1 and if_valid=0 next cycle and for
//     20 further cycles.
//     Repeat with halt and redirect together -> not halted, fetch restarts at redirect_pc.
//  6. RESET_PC=16'hFFFE -> first two imem_addr=16'hFFFE, 16'h0000; first if_pc_inc=16'h0000.
//     Rerun tests 2 and 4 with FETCH_BYPASS_EN: if_valid same cycle as imem_valid when queue empty.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, keeps up to DEPTH reads queued or in flight, feeds decode.
// Latency: imem_valid -> if_valid is 1 cycle, or 0 cycles with FETCH_BYPASS_EN defined and the queue empty.
// Backpressure: if_ready=0 holds the head stable; issue stalls once queued + in-flight reaches DEPTH.
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_inc,
  output logic        halted
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW  = 8;

  typedef enum logic {S_RUN, S_HALTED} state_t;
  state_t state_q, state_d;

  logic [15:0]   pc_q, ret_pc_q, redirect_tgt;
  logic [CW-1:0] count_q, inflight_q, infl_left;
  logic [DW-1:0] drop_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW1-1:0] occ_total;
  logic [15:0]   q_instr [DEPTH];
  logic [15:0]   q_pinc  [DEPTH];

  logic in_run, flush_redir, flush_halt, flush;
  logic resp_drop, resp_take, head_vld, byp_vld, pop, byp_take, push;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  // Redirect has priority over halt; HALTED is left only through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && halt && !redirect) state_d = S_HALTED;
  end

  always_comb begin
    halted = rst && (state_q == S_HALTED);
  end

  always_comb begin
    in_run       = rst && (state_q == S_RUN);
    flush_redir  = in_run && redirect;
    flush_halt   = in_run && halt && !redirect;
    flush        = flush_redir || flush_halt;
    redirect_tgt = redirect_pc & 16'hFFFE;
    resp_drop    = rst && imem_valid && (drop_q != '0);
    resp_take    = rst && imem_valid && (drop_q == '0) && (inflight_q != '0);
    infl_left    = inflight_q - CW'(resp_take);
    head_vld     = in_run && (count_q != '0);
`ifdef FETCH_BYPASS_EN
    byp_vld      = in_run && !flush && resp_take && (count_q == '0);
`else
    byp_vld      = 1'b0;
`endif
    pop          = head_vld && if_ready;
    byp_take     = byp_vld && if_ready;
    push         = resp_take && !flush && !byp_take;
    // A pop this cycle frees its slot, so issue can continue back-to-back at DEPTH=2.
    occ_total    = CW1'(count_q) + CW1'(inflight_q) - CW1'(pop);
    imem_req     = in_run && !redirect && !halt && (occ_total < CW1'(DEPTH));
    imem_addr    = pc_q;
    if_valid     = head_vld || byp_vld;
    if_instr     = '0;
    if_pc_inc    = '0;
    if (head_vld) begin
      if_instr  = q_instr[rd_ptr_q];
      if_pc_inc = q_pinc[rd_ptr_q];
    end else if (byp_vld) begin
      if_instr  = imem_data;
      if_pc_inc = ret_pc_q + 16'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ret_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      // ret_pc_q tracks the address of the next response that will be kept.
      if (flush_redir) begin
        pc_q     <= redirect_tgt;
        ret_pc_q <= redirect_tgt;
      end else begin
        if (imem_req)  pc_q     <= pc_q + 16'd2;
        if (resp_take) ret_pc_q <= ret_pc_q + 16'd2;
      end
      drop_q <= drop_q - DW'(resp_drop) + (flush ? DW'(infl_left) : DW'(0));
      if (flush) begin
        count_q    <= '0;
        inflight_q <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        inflight_q <= inflight_q + CW'(imem_req) - CW'(resp_take);
        count_q    <= count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_q <= inc_ptr(wr_ptr_q);
        if (pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= imem_data;
      q_pinc[wr_ptr_q]  <= ret_pc_q + 16'd2;
    end
  end
endmodule
